// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder slice.
package mem_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_word_array.sv
// Word-addressed byte-writable storage with a synchronous write and a registered,
// enable-held read port.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Load/store port responder: one request at a time, answered after WAIT_CYCLES wait
// states, with alignment/range error reporting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_byte_en,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                r_we, r_err;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_idx;
  logic [WORD_W-1:0]   r_wdata;

  logic                w_accept, w_enter_resp, w_req_err, w_from_req;
  logic                w_cur_we, w_cur_err, w_arr_we, w_arr_re;
  logic [BE_W-1:0]     w_cur_be;
  logic [ADDR_W-1:0]   w_cur_idx;
  logic [WORD_W-1:0]   w_cur_wdata, w_arr_rdata;

  assign w_accept  = req_valid & req_ready;
  assign w_req_err = (req_addr[1:0] != 2'b00) | ((req_addr >> (ADDR_W + 2)) != '0);

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = rst_n;
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next     = WAIT;
            w_cnt_next = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // With zero wait states the array access happens on the accept edge itself, so the
  // array port takes the live request in IDLE and the latched copy otherwise.
  assign w_from_req  = (r_state == IDLE);
  assign w_cur_we    = w_from_req ? req_we      : r_we;
  assign w_cur_err   = w_from_req ? w_req_err   : r_err;
  assign w_cur_be    = w_from_req ? req_byte_en : r_be;
  assign w_cur_idx   = w_from_req ? req_addr[ADDR_W+1:2] : r_idx;
  assign w_cur_wdata = w_from_req ? req_wdata   : r_wdata;
  assign w_arr_we    = w_enter_resp &  w_cur_we & ~w_cur_err;
  assign w_arr_re    = w_enter_resp & ~w_cur_we & ~w_cur_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_be    <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_err   <= w_req_err;
        r_be    <= req_byte_en;
        r_idx   <= req_addr[ADDR_W+1:2];
        r_wdata <= req_wdata;
      end
    end
  end

  mem_word_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_be    (w_cur_be),
    .i_re    (w_arr_re),
    .i_addr  (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_arr_rdata)
  );

  assign resp_rdata = (r_state == RESP && !r_we && !r_err) ? w_arr_rdata : '0;
  assign resp_err   = (r_state == RESP) & r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [3:0]  req_byte_en;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
  logic [3:0]  z_req_byte_en;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte_en(req_byte_en), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_byte_en(z_req_byte_en), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; returns negedges until resp_valid (bounded).
  task automatic wait_resp(input string tag, output int l);
    l = 0;
    while (resp_valid !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
      if (resp_valid !== 1'b1) chk({tag, "_wait_rdy"}, {31'b0, req_ready}, 32'd0);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int l;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte_en = be; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b1;
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(tag, l);
    chk({tag, "_lat"}, l, 32'd3);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
  endtask

  task automatic z_write(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_byte_en = 4'hF;
    z_req_addr = addr; z_req_wdata = wdata; z_resp_ready = 1'b1;
    chk("z_wr_rdy", {31'b0, z_req_ready}, 32'd1);
    @(negedge clk);
    chk("z_wr_valid", {31'b0, z_resp_valid}, 32'd1);
    chk("z_wr_err", {31'b0, z_resp_err}, 32'd0);
    z_req_valid = 1'b0;
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte_en = 4'h0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_byte_en = 4'h0; z_req_addr = '0;
    z_req_wdata = '0; z_resp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rdy", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", {31'b0, req_ready}, 32'd1);
    chk("z_post_rst_rdy", {31'b0, z_req_ready}, 32'd1);

    // Full-word write then read back
    xact("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("rd10", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge
    xact("wr20", 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
    xact("wr20be", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
    xact("rd20", 1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);

    // Errors: misaligned read, out-of-range write aliasing word 0 must not write
    xact("wr00", 1'b1, 4'hF, 32'h0, 32'h01020304, 32'h0, 1'b0);
    xact("rd21", 1'b0, 4'hF, 32'h21, 32'h0, 32'h0, 1'b1);
    xact("wr_oor", 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("rd00", 1'b0, 4'hF, 32'h0, 32'h0, 32'h01020304, 1'b0);

    // Empty byte mask is a no-op write; top word is in range
    xact("wr_be0", 1'b1, 4'h0, 32'h10, 32'h0, 32'h0, 1'b0);
    xact("rd10b", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("wr_top", 1'b1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("rd_top", 1'b0, 4'hF, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);

    // Back-pressure with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; resp_ready = 1'b0;
    chk("bp_rdy", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    wait_resp("bp", lat);
    chk("bp_lat", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'h11BB33DD);
      chk("bp_err", {31'b0, resp_err}, 32'd0);
      chk("bp_hold_rdy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_valid_end", {31'b0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    req_addr = 32'h10;
    @(negedge clk);
    chk("bp_next_rdy", {31'b0, req_ready}, 32'd1);
    chk("bp_next_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp("bp2", lat);
    chk("bp2_lat", lat, 32'd3);
    chk("bp2_rdata", resp_rdata, 32'hDEADBEEF);

    // Zero-wait instance: back-to-back reads with req_valid held
    z_write(32'h4, 32'h00000055);
    z_write(32'h8, 32'h00000066);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h4;
    chk("z_rd1_rdy", {31'b0, z_req_ready}, 32'd1);
    @(negedge clk);
    chk("z_rd1_valid", {31'b0, z_resp_valid}, 32'd1);
    chk("z_rd1_rdata", z_resp_rdata, 32'h55);
    chk("z_rd1_busy", {31'b0, z_req_ready}, 32'd0);
    z_req_addr = 32'h8;
    @(negedge clk);
    chk("z_rd2_rdy", {31'b0, z_req_ready}, 32'd1);
    chk("z_rd2_idle_valid", {31'b0, z_resp_valid}, 32'd0);
    @(negedge clk);
    chk("z_rd2_valid", {31'b0, z_resp_valid}, 32'd1);
    chk("z_rd2_rdata", z_resp_rdata, 32'h66);
    z_req_valid = 1'b0;

    // Reset during WAIT of a write abandons it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte_en = 4'hF; req_addr = 32'h10;
    req_wdata = 32'h12345678;
    chk("rw_rdy", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rw_rst_rdy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rw_rst_valid2", {31'b0, resp_valid}, 32'd0);
    chk("rw_rst_rdy2", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rw_rel_rdy", {31'b0, req_ready}, 32'd1);
    chk("rw_rel_valid", {31'b0, resp_valid}, 32'd0);
    xact("rw_rd10", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
